// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and helpers for the load/store-multiple sequencer.
//  - state_e     : sequencer states
//  - amode_e     : ARM addressing mode (IA/IB/DA/DB) from up/pre bits
//  - mode_t      : per-operation flags latched at start
//  - popcount16  : number of registers in a 16-bit list
package ldm_stm_seq_pkg;

   localparam int unsigned LIST_W     = 16;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      AM_IA = 2'd0,
      AM_IB = 2'd1,
      AM_DA = 2'd2,
      AM_DB = 2'd3
   } amode_e;

   typedef struct packed {
      logic is_load;
      logic up;
      logic pre;
      logic wback;
   } mode_t;

   // Number of set bits in a register list (0..16).
   function automatic logic [CNT_W-1:0] popcount16(input logic [LIST_W-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(LIST_W); i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   // up/pre pair to addressing mode.
   function automatic amode_e decode_amode(input logic up, input logic pre);
      amode_e m;
      case ({up, pre})
         2'b10:   m = AM_IA;
         2'b11:   m = AM_IB;
         2'b00:   m = AM_DA;
         default: m = AM_DB;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// Lowest-set-bit encoder for the pending register mask.
//  mask  in  16  pending registers
//  idx   out 4   index of lowest set bit (0 when mask is empty)
//  valid out 1   mask has at least one bit set
module ldm_stm_seq_prio_enc16
   import ldm_stm_seq_pkg::*;
(
   input  logic [LIST_W-1:0] mask,
   output logic [IDX_W-1:0]  idx,
   output logic              valid
);

   // Scan high-to-low so the lowest set bit is the last one to win.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer (ARM LDM/STM).
// Walks reg_list lowest-first, one memory handshake per register, then
// optionally writes the final address back to the base register.
//  clk, rst_n                      clock, async active-low reset
//  start, is_load, up, pre, wback  request and mode (sampled in IDLE only)
//  base_reg, base_addr, reg_list   Rn index, Rn value, transfer list
//  rf_read_addr / rf_read_data     reg_file read port (STM source data)
//  rf_wr_en / rf_write_addr/_data  reg_file write port (LDM data, writeback)
//  mem_req/we/addr/wdata/rdata/ack memory handshake, ack completes same cycle
//  busy, done                      status; done is a one-cycle pulse
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 16
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     is_load,
   input  logic                     up,
   input  logic                     pre,
   input  logic                     wback,
   input  logic [IDX_W-1:0]         base_reg,
   input  logic [DATA_W-1:0]        base_addr,
   input  logic [NREGS-1:0]         reg_list,
   output logic [IDX_W-1:0]         rf_read_addr,
   input  logic [DATA_W-1:0]        rf_read_data,
   output logic                     rf_wr_en,
   output logic [IDX_W-1:0]         rf_write_addr,
   output logic [DATA_W-1:0]        rf_write_data,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [DATA_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack,
   output logic                     busy,
   output logic                     done
);

   state_e            state_q, state_d;
   mode_t             mode_q, mode_d;
   logic [IDX_W-1:0]  base_reg_q, base_reg_d;
   logic [NREGS-1:0]  list_q, list_d;
   logic [NREGS-1:0]  mask_q, mask_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] final_q, final_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [IDX_W-1:0]  cur_idx;
   logic              cur_valid;
   logic              wb_needed;

   logic [DATA_W-1:0] base_al;
   logic [DATA_W-1:0] span;
   logic [DATA_W-1:0] start_addr;
   logic [DATA_W-1:0] final_addr;
   logic              base_lo_unused;

   // Word alignment drops the byte-offset bits of the base.
   assign base_lo_unused = ^base_addr[1:0];

   ldm_stm_seq_prio_enc16 u_enc (
      .mask  (mask_q),
      .idx   (cur_idx),
      .valid (cur_valid)
   );

   // First transfer address and final (writeback) address from the request.
   always_comb begin
      base_al = {base_addr[DATA_W-1:2], 2'b00};
      span    = DATA_W'(popcount16(reg_list)) << 2;
      case (decode_amode(up, pre))
         AM_IA:   start_addr = base_al;
         AM_IB:   start_addr = base_al + DATA_W'(WORD_BYTES);
         AM_DA:   start_addr = base_al - span + DATA_W'(WORD_BYTES);
         default: start_addr = base_al - span;
      endcase
      final_addr = up ? (base_al + span) : (base_al - span);
   end

   // A loaded base register keeps the loaded value, so writeback is dropped.
   assign wb_needed = mode_q.wback && !(mode_q.is_load && list_q[base_reg_q]);

   // Next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      base_reg_d    = base_reg_q;
      list_d        = list_q;
      mask_d        = mask_q;
      addr_d        = addr_q;
      final_d       = final_q;
      rf_read_addr  = '0;
      rf_wr_en      = 1'b0;
      rf_write_addr = '0;
      rf_write_data = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d     = '{is_load: is_load, up: up, pre: pre, wback: wback};
               base_reg_d = base_reg;
               list_d     = reg_list;
               mask_d     = reg_list;
               addr_d     = start_addr;
               final_d    = final_addr;
               state_d    = (reg_list == '0) ? S_DONE : S_XFER;
            end
         end

         S_XFER: begin
            if (cur_valid) begin
               mem_req  = 1'b1;
               mem_we   = ~mode_q.is_load;
               mem_addr = addr_q;
               if (!mode_q.is_load) begin
                  rf_read_addr = cur_idx;
                  mem_wdata    = rf_read_data;
               end
               if (mem_ack) begin
                  if (mode_q.is_load) begin
                     rf_wr_en      = 1'b1;
                     rf_write_addr = cur_idx;
                     rf_write_data = mem_rdata;
                  end
                  mask_d = mask_q & ~(NREGS'(1) << cur_idx);
                  addr_d = addr_q + DATA_W'(WORD_BYTES);
               end
            end else begin
               // Drain cycle after the last beat: no request, decide writeback.
               state_d = wb_needed ? S_WB : S_DONE;
            end
         end

         S_WB: begin
            rf_wr_en      = 1'b1;
            rf_write_addr = base_reg_q;
            rf_write_data = final_q;
            state_d       = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         base_reg_q <= '0;
         list_q     <= '0;
         mask_q     <= '0;
         addr_q     <= '0;
         final_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         base_reg_q <= base_reg_d;
         list_q     <= list_d;
         mask_q     <= mask_d;
         addr_q     <= addr_d;
         final_q    <= final_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq with a behavioural reg_file and word memory.
module tb_ldm_stm_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, is_load, up, pre, wback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic [3:0]  rf_read_addr;
   logic [31:0] rf_read_data;
   logic        rf_wr_en;
   logic [3:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, done;

   always #5 clk = ~clk;

   ldm_stm_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up),
      .pre(pre), .wback(wback), .base_reg(base_reg), .base_addr(base_addr),
      .reg_list(reg_list), .rf_read_addr(rf_read_addr),
      .rf_read_data(rf_read_data), .rf_wr_en(rf_wr_en),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .done(done)
   );

   // Environment: register file, word memory, ack with programmable wait.
   logic [31:0] rf  [0:15];
   logic [31:0] mem [0:255];
   logic        pl_en, pl_rf;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;
   int          ack_delay;
   int          wait_cnt = 0;

   assign rf_read_data = rf[rf_read_addr];
   assign mem_rdata    = mem[mem_addr[9:2]];
   assign mem_ack      = mem_req && (wait_cnt >= ack_delay);

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (rf_wr_en) rf[rf_write_addr] <= rf_write_data;
      if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (pl_en) begin
         if (pl_rf) rf[pl_idx[3:0]] <= pl_data;
         else       mem[pl_idx]     <= pl_data;
      end
   end

   int vecs  = 0;
   int fails = 0;

   // Per-run observations.
   int          n_acks, n_rf_wr;
   logic [31:0] ack_addr [$];
   logic        unstable;

   task automatic poke(input logic is_rf, input logic [7:0] idx, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_rf = is_rf; pl_idx = idx; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Pulse start in cycle 0 and observe cycles 1.. at the falling edge.
   task automatic run_seq(input logic ld, input logic up_i, input logic pre_i,
                          input logic wb_i, input logic [3:0] rn,
                          input logic [31:0] base, input logic [15:0] list,
                          input int busy_start_cyc, input int rst_cyc,
                          output int done_cyc, output int first_req);
      logic        pend;
      logic [31:0] h_addr, h_wd;
      logic        h_we;
      done_cyc = -1; first_req = -1; n_acks = 0; n_rf_wr = 0;
      ack_addr.delete(); unstable = 1'b0; pend = 1'b0;
      h_addr = '0; h_wd = '0; h_we = 1'b0;
      @(negedge clk);
      is_load = ld; up = up_i; pre = pre_i; wback = wb_i;
      base_reg = rn; base_addr = base; reg_list = list; start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = (c == busy_start_cyc);
         if (c == busy_start_cyc) begin
            reg_list = 16'hFFFF; base_addr = 32'h0000_0FF0;
         end
         if (c == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            return;
         end
         if (mem_req) begin
            if (first_req < 0) first_req = c;
            if (pend && (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wd))
               unstable = 1'b1;
            h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
            pend = !mem_ack;
            if (mem_ack) begin
               n_acks++;
               ack_addr.push_back(mem_addr);
            end
         end else begin
            pend = 1'b0;
         end
         if (rf_wr_en) n_rf_wr++;
         if (done && done_cyc < 0) done_cyc = c;
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
   endtask

   task automatic test_reset;
      #1;
      vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      vecs++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      vecs++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      vecs++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL reset_rf_wr_en: got %b want 0", rf_wr_en); end
      vecs++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      for (int i = 0; i < 16; i++) poke(1'b1, 8'(i), 32'hA000_0000 + 32'(i));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // STMIA {r1,r3,r5}, base 0x100, Rn=r13 with writeback.
   task automatic test_stmia;
      int dc, fr;
      run_seq(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'b0000_0000_0010_1010, 0, 0, dc, fr);
      vecs++; if (dc !== 6) begin fails++; $display("FAIL stmia_done_cycle: got %0d want 6", dc); end
      vecs++; if (fr !== 1) begin fails++; $display("FAIL stmia_first_req: got %0d want 1", fr); end
      vecs++; if (n_acks !== 3) begin fails++; $display("FAIL stmia_acks: got %0d want 3", n_acks); end
      vecs++; if (ack_addr[0] !== 32'h100) begin fails++; $display("FAIL stmia_addr0: got %h want 100", ack_addr[0]); end
      vecs++; if (ack_addr[1] !== 32'h104) begin fails++; $display("FAIL stmia_addr1: got %h want 104", ack_addr[1]); end
      vecs++; if (ack_addr[2] !== 32'h108) begin fails++; $display("FAIL stmia_addr2: got %h want 108", ack_addr[2]); end
      vecs++; if (mem[8'h40] !== 32'hA000_0001) begin fails++; $display("FAIL stmia_mem100: got %h want a0000001", mem[8'h40]); end
      vecs++; if (mem[8'h41] !== 32'hA000_0003) begin fails++; $display("FAIL stmia_mem104: got %h want a0000003", mem[8'h41]); end
      vecs++; if (mem[8'h42] !== 32'hA000_0005) begin fails++; $display("FAIL stmia_mem108: got %h want a0000005", mem[8'h42]); end
      vecs++; if (rf[13] !== 32'h10C) begin fails++; $display("FAIL stmia_wb_r13: got %h want 10c", rf[13]); end
   endtask

   // LDMDB {r0,r15}, base 0x200, Rn=r2 with writeback.
   task automatic test_ldmdb;
      int dc, fr;
      poke(1'b0, 8'h7E, 32'h1111_2222);
      poke(1'b0, 8'h7F, 32'h3333_4444);
      run_seq(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h200, 16'b1000_0000_0000_0001, 0, 0, dc, fr);
      vecs++; if (dc !== 5) begin fails++; $display("FAIL ldmdb_done_cycle: got %0d want 5", dc); end
      vecs++; if (ack_addr[0] !== 32'h1F8) begin fails++; $display("FAIL ldmdb_addr0: got %h want 1f8", ack_addr[0]); end
      vecs++; if (ack_addr[1] !== 32'h1FC) begin fails++; $display("FAIL ldmdb_addr1: got %h want 1fc", ack_addr[1]); end
      vecs++; if (rf[0] !== 32'h1111_2222) begin fails++; $display("FAIL ldmdb_r0: got %h want 11112222", rf[0]); end
      vecs++; if (rf[15] !== 32'h3333_4444) begin fails++; $display("FAIL ldmdb_r15: got %h want 33334444", rf[15]); end
      vecs++; if (rf[2] !== 32'h1F8) begin fails++; $display("FAIL ldmdb_wb_r2: got %h want 1f8", rf[2]); end
   endtask

   // LDMIA {r2,r4} with Rn=r2 in the list: loaded value wins, no writeback.
   task automatic test_ldm_base_in_list;
      int dc, fr;
      poke(1'b0, 8'h10, 32'h5555_AAAA);
      poke(1'b0, 8'h11, 32'h0BAD_F00D);
      run_seq(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h40, 16'b0000_0000_0001_0100, 0, 0, dc, fr);
      vecs++; if (rf[2] !== 32'h5555_AAAA) begin fails++; $display("FAIL ldm_base_r2: got %h want 5555aaaa", rf[2]); end
      vecs++; if (rf[4] !== 32'h0BAD_F00D) begin fails++; $display("FAIL ldm_base_r4: got %h want 0badf00d", rf[4]); end
      vecs++; if (n_rf_wr !== 2) begin fails++; $display("FAIL ldm_base_rf_writes: got %0d want 2", n_rf_wr); end
      vecs++; if (dc !== 4) begin fails++; $display("FAIL ldm_base_done_cycle: got %0d want 4", dc); end
   endtask

   // Empty list: straight to DONE, no traffic.
   task automatic test_empty_list;
      int dc, fr;
      run_seq(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h80, 16'h0000, 0, 0, dc, fr);
      vecs++; if (dc !== 1) begin fails++; $display("FAIL empty_done_cycle: got %0d want 1", dc); end
      vecs++; if (fr !== -1) begin fails++; $display("FAIL empty_mem_req: first req cycle %0d want none (-1)", fr); end
      vecs++; if (n_acks !== 0) begin fails++; $display("FAIL empty_acks: got %0d want 0", n_acks); end
      vecs++; if (n_rf_wr !== 0) begin fails++; $display("FAIL empty_rf_writes: got %0d want 0", n_rf_wr); end
   endtask

   // STMIB {r7}, base 0x300, three wait states, start pulsed while busy.
   task automatic test_wait_and_busy_start;
      int dc, fr;
      ack_delay = 3;
      run_seq(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h300, 16'b0000_0000_1000_0000, 2, 0, dc, fr);
      ack_delay = 0;
      vecs++; if (mem[8'hC1] !== 32'hA000_0007) begin fails++; $display("FAIL stmib_mem304: got %h want a0000007", mem[8'hC1]); end
      vecs++; if (n_acks !== 1) begin fails++; $display("FAIL stmib_acks: got %0d want 1", n_acks); end
      vecs++; if (ack_addr[0] !== 32'h304) begin fails++; $display("FAIL stmib_addr: got %h want 304", ack_addr[0]); end
      vecs++; if (unstable !== 1'b0) begin fails++; $display("FAIL stmib_hold_stable: got %b want 0", unstable); end
      vecs++; if (dc !== 6) begin fails++; $display("FAIL stmib_done_cycle: got %0d want 6", dc); end
      vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL stmib_busy_after: got %b want 0", busy); end
   endtask

   // LDMIA r8-r11 interrupted by reset after the second beat, then rerun.
   task automatic test_reset_mid_seq;
      int dc, fr;
      for (int i = 0; i < 4; i++) begin
         poke(1'b1, 8'(8 + i), 32'hDEAD_0008 + 32'(i));
         poke(1'b0, 8'(8'h20 + 8'(i)), 32'h1111_0080 + 32'(4 * i));
      end
      run_seq(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h80, 16'h0F00, 0, 3, dc, fr);
      vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      vecs++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_mem_req: got %b want 0", mem_req); end
      vecs++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL rst_mid_rf_wr_en: got %b want 0", rf_wr_en); end
      vecs++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b want 0", done); end
      @(negedge clk);
      @(negedge clk);
      vecs++; if (rf[8] !== 32'h1111_0080) begin fails++; $display("FAIL rst_mid_r8: got %h want 11110080", rf[8]); end
      vecs++; if (rf[9] !== 32'h1111_0084) begin fails++; $display("FAIL rst_mid_r9: got %h want 11110084", rf[9]); end
      vecs++; if (rf[10] !== 32'hDEAD_000A) begin fails++; $display("FAIL rst_mid_r10: got %h want dead000a", rf[10]); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) poke(1'b0, 8'(8'h20 + 8'(i)), 32'h2222_0080 + 32'(4 * i));
      run_seq(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h80, 16'h0F00, 0, 0, dc, fr);
      vecs++; if (dc !== 6) begin fails++; $display("FAIL rerun_done_cycle: got %0d want 6", dc); end
      vecs++; if (n_acks !== 4) begin fails++; $display("FAIL rerun_acks: got %0d want 4", n_acks); end
      vecs++; if (rf[8] !== 32'h2222_0080) begin fails++; $display("FAIL rerun_r8: got %h want 22220080", rf[8]); end
      vecs++; if (rf[9] !== 32'h2222_0084) begin fails++; $display("FAIL rerun_r9: got %h want 22220084", rf[9]); end
      vecs++; if (rf[10] !== 32'h2222_0088) begin fails++; $display("FAIL rerun_r10: got %h want 22220088", rf[10]); end
      vecs++; if (rf[11] !== 32'h2222_008C) begin fails++; $display("FAIL rerun_r11: got %h want 2222008c", rf[11]); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0;
      wback = 1'b0; base_reg = '0; base_addr = '0; reg_list = '0;
      pl_en = 1'b0; pl_rf = 1'b0; pl_idx = '0; pl_data = '0; ack_delay = 0;
      test_reset;
      test_stmia;
      test_ldmdb;
      test_ldm_base_in_list;
      test_empty_list;
      test_wait_and_busy_start;
      test_reset_mid_seq;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
